dcache_controller: RTL and testbench

Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller. A read hit returns in the request cycle. A read miss fetches a 64-bit line (two words) over the SRAM controller's 64-bit read path and fills it into the cache. Writes always go through to SRAM and update the cached word on a hit. The pipeline freezes on ~ready.

---
 rtl/dcache_controller_if.sv | 26 ++
 rtl/dcache_controller.sv | 133 +++++++++++++
 tb/tb_dcache_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_controller_if.sv
// Bundle of the MEM-stage request bus and the SRAM-controller bus seen by dcache_controller.
// The master side is the environment (pipeline plus SRAM controller); the slave side is the cache.
interface dcache_controller_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read;
  logic        sram_write;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport master (
    output MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
    input  rdata, ready, sram_address, sram_wdata, sram_read, sram_write
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
    output rdata, ready, sram_address, sram_wdata, sram_read, sram_write
  );
endinterface

// File: rtl/dcache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache with two-word lines.
// Read hits complete in the request cycle; misses fetch a full 64-bit line from SRAM.
module dcache_controller #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 10
) (
  input logic              clk,
  input logic              rst,
  dcache_controller_if.slave bus
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_LO = 3 + INDEX_W;
  localparam int TAG_HI = TAG_LO + TAG_W - 1;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t            state;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [31:0]       data_mem [2][SETS][2];

  // Incoming request fields (IDLE) and latched fields (RD_MISS / WR_THRU).
  logic [INDEX_W-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0]   req_tag, miss_tag;
  logic               req_word, miss_word;
  logic               hit0, hit1, hit, hit_way, fill_way;
  logic               wr_hit_en, fill_en;
  logic               unused_addr;

  assign req_idx   = bus.address[TAG_LO-1:3];
  assign req_tag   = bus.address[TAG_HI:TAG_LO];
  assign req_word  = bus.address[2];
  assign miss_idx  = addr_q[TAG_LO-1:3];
  assign miss_tag  = addr_q[TAG_HI:TAG_LO];
  assign miss_word = addr_q[2];
  assign unused_addr = ^{bus.address[31:TAG_HI+1], bus.address[1:0]};

  assign hit0     = valid_q[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
  assign hit1     = valid_q[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign fill_way = lru_q[miss_idx];

  assign wr_hit_en = !rst && (state == IDLE) && bus.MEM_W_EN && hit;
  assign fill_en   = !rst && (state == RD_MISS) && bus.sram_ready;

  // NOTE: tag and data arrays carry no reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (wr_hit_en)
      data_mem[hit_way][req_idx][req_word] <= bus.wdata;
    if (fill_en) begin
      tag_mem[fill_way][miss_idx]     <= miss_tag;
      data_mem[fill_way][miss_idx][0] <= bus.sram_rdata[31:0];
      data_mem[fill_way][miss_idx][1] <= bus.sram_rdata[63:32];
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.MEM_W_EN) begin
            addr_q  <= bus.address;
            wdata_q <= bus.wdata;
            state   <= WR_THRU;
            if (hit) lru_q[req_idx] <= ~hit_way;
          end else if (bus.MEM_R_EN) begin
            if (hit) begin
              lru_q[req_idx] <= ~hit_way;
            end else begin
              addr_q <= bus.address;
              state  <= RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (bus.sram_ready) begin
            valid_q[fill_way][miss_idx] <= 1'b1;
            lru_q[miss_idx]             <= ~fill_way;
            state                       <= IDLE;
          end
        end
        WR_THRU: if (bus.sram_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    bus.ready = 1'b0;
    bus.rdata = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.MEM_W_EN) begin
            bus.ready = 1'b0;
          end else if (bus.MEM_R_EN) begin
            bus.ready = hit;
            if (hit) bus.rdata = data_mem[hit_way][req_idx][req_word];
          end else begin
            bus.ready = 1'b1;
          end
        end
        RD_MISS: begin
          if (bus.sram_ready) begin
            bus.ready = 1'b1;
            bus.rdata = miss_word ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
          end
        end
        WR_THRU: bus.ready = bus.sram_ready;
        default: ;
      endcase
    end
  end

  // SRAM strobes decode the state alone, so they are never high together.
  assign bus.sram_read    = !rst && (state == RD_MISS);
  assign bus.sram_write   = !rst && (state == WR_THRU);
  assign bus.sram_address = rst ? 32'h0 : addr_q;
  assign bus.sram_wdata   = rst ? 32'h0 : wdata_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller: fills, LRU eviction, write-through,
// no-write-allocate, a long SRAM stall and reset in the middle of a miss.
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  dcache_controller_if bus ();

  dcache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_op(input string tag, input logic [31:0] addr, input logic [63:0] line,
                         input logic [31:0] exp, input bit exp_hit);
    bus.address  = addr;
    bus.MEM_R_EN = 1'b1;
    #1;
    if (exp_hit) begin
      check({tag, "_hit_ready"}, bus.ready, 1'b1);
      check({tag, "_hit_rdata"}, bus.rdata, exp);
      tick();
      check({tag, "_hit_no_sram"}, bus.sram_read, 1'b0);
    end else begin
      check({tag, "_miss_ready"}, bus.ready, 1'b0);
      tick();
      check({tag, "_sram_read"}, bus.sram_read, 1'b1);
      check({tag, "_sram_addr"}, bus.sram_address, addr);
      bus.sram_rdata = line;
      bus.sram_ready = 1'b1;
      #1;
      check({tag, "_fill_ready"}, bus.ready, 1'b1);
      check({tag, "_fill_rdata"}, bus.rdata, exp);
      tick();
      bus.sram_ready = 1'b0;
      check({tag, "_post_fill_idle"}, bus.sram_read, 1'b0);
    end
    bus.MEM_R_EN = 1'b0;
  endtask

  task automatic write_op(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input bit with_read);
    bus.address  = addr;
    bus.wdata    = data;
    bus.MEM_W_EN = 1'b1;
    bus.MEM_R_EN = with_read;
    #1;
    check({tag, "_ready_low"}, bus.ready, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      check({tag, "_sram_write"}, bus.sram_write, 1'b1);
      check({tag, "_no_read"}, bus.sram_read, 1'b0);
      check({tag, "_sram_addr"}, bus.sram_address, addr);
      check({tag, "_sram_wdata"}, bus.sram_wdata, data);
      check({tag, "_wait_ready"}, bus.ready, 1'b0);
      if (i == 0) tick();
    end
    bus.sram_ready = 1'b1;
    #1;
    check({tag, "_done_ready"}, bus.ready, 1'b1);
    tick();
    bus.sram_ready = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.MEM_R_EN   = 1'b0;
    check({tag, "_post_idle"}, bus.sram_write, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.address    = '0;
    bus.wdata      = '0;
    bus.sram_rdata = '0;
    bus.sram_ready = 1'b0;
    #1;
    check("rst_ready", bus.ready, 1'b0);
    check("rst_sram_read", bus.sram_read, 1'b0);
    check("rst_sram_write", bus.sram_write, 1'b0);
    check("rst_sram_addr", bus.sram_address, 32'h0);
    check("rst_sram_wdata", bus.sram_wdata, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("idle_ready", bus.ready, 1'b1);
    check("idle_sram_read", bus.sram_read, 1'b0);

    // Basic fill and hits on both words of the line.
    read_op("t1_miss_400", 32'h400, 64'h2222_2222_1111_1111, 32'h1111_1111, 1'b0);
    read_op("t1_hit_400", 32'h400, '0, 32'h1111_1111, 1'b1);
    read_op("t1_hit_404", 32'h404, '0, 32'h2222_2222, 1'b1);

    // Same-index conflict: 0x600 lands in the other way, 0x800 evicts the least recently used.
    read_op("t2_miss_600", 32'h600, 64'h6666_6666_5555_5555, 32'h5555_5555, 1'b0);
    read_op("t2_hit_400a", 32'h400, '0, 32'h1111_1111, 1'b1);
    read_op("t2_miss_800", 32'h800, 64'h8888_8888_7777_7777, 32'h7777_7777, 1'b0);
    read_op("t2_hit_400b", 32'h400, '0, 32'h1111_1111, 1'b1);
    read_op("t2_miss_600b", 32'h600, 64'h6666_6666_5555_5555, 32'h5555_5555, 1'b0);

    // Write hit updates the cached word only.
    write_op("t3_wr_400", 32'h400, 32'hDEAD_BEEF, 1'b0);
    read_op("t3_hit_400", 32'h400, '0, 32'hDEAD_BEEF, 1'b1);
    read_op("t3_hit_404", 32'h404, '0, 32'h2222_2222, 1'b1);

    // Simultaneous read and write enables behave as a write.
    write_op("t3_rw_404", 32'h404, 32'h0BAD_F00D, 1'b1);
    read_op("t3_hit_404b", 32'h404, '0, 32'h0BAD_F00D, 1'b1);

    // Write miss must not allocate.
    write_op("t4_wr_a00", 32'hA00, 32'h1234_5678, 1'b0);
    read_op("t4_miss_a00", 32'hA00, 64'hAAAA_AAAA_9999_9999, 32'h9999_9999, 1'b0);

    // sram_ready seen in IDLE is ignored.
    bus.sram_ready = 1'b1;
    tick();
    bus.sram_ready = 1'b0;
    check("idle_pulse_ready", bus.ready, 1'b1);
    check("idle_pulse_no_read", bus.sram_read, 1'b0);

    // Long SRAM stall with the address pins wandering.
    bus.address  = 32'hC00;
    bus.MEM_R_EN = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.address = 32'h0000_0123 + 32'(i * 8);
      #1;
      check("t5_stall_ready", bus.ready, 1'b0);
      check("t5_stall_read", bus.sram_read, 1'b1);
      check("t5_stall_addr", bus.sram_address, 32'hC00);
      tick();
    end
    bus.address    = 32'hC00;
    bus.sram_rdata = 64'hDDDD_DDDD_CCCC_CCCC;
    bus.sram_ready = 1'b1;
    #1;
    check("t5_fill_ready", bus.ready, 1'b1);
    check("t5_fill_rdata", bus.rdata, 32'hCCCC_CCCC);
    tick();
    bus.sram_ready = 1'b0;
    bus.MEM_R_EN   = 1'b0;
    read_op("t5_hit_c04", 32'hC04, '0, 32'hDDDD_DDDD, 1'b1);

    // Reset in the middle of a miss abandons it and invalidates the cache.
    bus.address  = 32'hE00;
    bus.MEM_R_EN = 1'b1;
    tick();
    check("t6_pre_rst_read", bus.sram_read, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", bus.ready, 1'b0);
    check("t6_rst_read", bus.sram_read, 1'b0);
    check("t6_rst_addr", bus.sram_address, 32'h0);
    tick();
    rst          = 1'b0;
    bus.MEM_R_EN = 1'b0;
    #1;
    check("t6_after_read", bus.sram_read, 1'b0);
    check("t6_after_ready", bus.ready, 1'b1);
    check("t6_after_addr", bus.sram_address, 32'h0);
    read_op("t6_miss_e00", 32'hE00, 64'hFFFF_FFFF_EEEE_EEEE, 32'hEEEE_EEEE, 1'b0);
    read_op("t6_miss_400", 32'h400, 64'h2222_2222_1111_1111, 32'h1111_1111, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
